// File: rtl/keypad_entry_ctrl.sv
// Keypad front-end that collects a digit and submits it to a lock, then tracks grant/reject/alarm/timeout.
// Optional build macro KEYPAD_PASSIN_MASK_EN: passin shows the digit only while an attempt is in flight.
module keypad_entry_ctrl #(
    parameter int unsigned ENTER_CYCLES = 2,
    parameter int unsigned RESP_TIMEOUT = 8,
    parameter int unsigned COOLDOWN     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       key_ok,
    input  logic       key_clr,
    input  logic       access,
    input  logic       alarm,
    input  logic [1:0] count,
    output logic [3:0] passin,
    output logic       enter,
    output logic       busy,
    output logic       granted,
    output logic       rejected,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SEND,
        S_WAIT,
        S_COOL
    } state_t;

    // One shared cycle counter, zeroed on entry to each timed state; compare against last cycle index.
    localparam logic [7:0] LP_ENTER_LAST = 8'(ENTER_CYCLES - 1);
    localparam logic [7:0] LP_RESP_LAST  = 8'(RESP_TIMEOUT - 1);
    localparam logic [7:0] LP_COOL_LAST  = 8'(COOLDOWN - 1);

    state_t     r_state;
    logic [3:0] r_digit;
    logic [1:0] r_cnt_snap;
    logic [7:0] r_cnt;
    logic [3:0] r_passin;
    logic       r_enter;
    logic       r_busy;
    logic       r_granted;
    logic       r_rejected;
    logic       r_timeout_err;

    state_t     w_state;
    logic [3:0] w_digit;
    logic [1:0] w_cnt_snap;
    logic [7:0] w_cnt;
    logic [3:0] w_passin;
    logic       w_enter;
    logic       w_busy;
    logic       w_granted;
    logic       w_rejected;
    logic       w_timeout_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_digit       <= '0;
            r_cnt_snap    <= '0;
            r_cnt         <= '0;
            r_passin      <= '0;
            r_enter       <= 1'b0;
            r_busy        <= 1'b0;
            r_granted     <= 1'b0;
            r_rejected    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_digit       <= w_digit;
            r_cnt_snap    <= w_cnt_snap;
            r_cnt         <= w_cnt;
            r_passin      <= w_passin;
            r_enter       <= w_enter;
            r_busy        <= w_busy;
            r_granted     <= w_granted;
            r_rejected    <= w_rejected;
            r_timeout_err <= w_timeout_err;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_digit       = r_digit;
        w_cnt_snap    = r_cnt_snap;
        w_cnt         = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        w_granted     = r_granted;
        w_rejected    = 1'b0;
        w_timeout_err = r_timeout_err;

        case (r_state)
            S_IDLE, S_ARMED: begin
                if (key_clr) begin
                    w_state       = S_IDLE;
                    w_digit       = '0;
                    w_granted     = 1'b0;
                    w_timeout_err = 1'b0;
                end else begin
                    if (key_valid) begin
                        w_state = S_ARMED;
                        w_digit = key_code;
                    end
                    if (key_ok && (r_state == S_ARMED)) begin
                        w_state       = S_SEND;
                        w_cnt_snap    = count;
                        w_cnt         = '0;
                        w_timeout_err = 1'b0;
                    end
                end
            end
            S_SEND: begin
                if (r_cnt == LP_ENTER_LAST) begin
                    w_state = S_WAIT;
                    w_cnt   = '0;
                end
            end
            S_WAIT: begin
                if (alarm) begin
                    w_state = S_COOL;
                    w_cnt   = '0;
                end else if (access) begin
                    w_state   = S_IDLE;
                    w_granted = 1'b1;
                end else if (count != r_cnt_snap) begin
                    w_state    = S_ARMED;
                    w_rejected = 1'b1;
                end else if (r_cnt == LP_RESP_LAST) begin
                    w_state       = S_ARMED;
                    w_timeout_err = 1'b1;
                end
            end
            S_COOL: begin
                if (r_cnt == LP_COOL_LAST) begin
                    w_state = S_IDLE;
                    w_digit = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        w_enter = (w_state == S_SEND);
        w_busy  = (w_state == S_SEND) || (w_state == S_WAIT) || (w_state == S_COOL);
`ifdef KEYPAD_PASSIN_MASK_EN
        w_passin = ((w_state == S_SEND) || (w_state == S_WAIT)) ? w_digit : '0;
`else
        w_passin = w_digit;
`endif
    end

    assign passin      = r_passin;
    assign enter       = r_enter;
    assign busy        = r_busy;
    assign granted     = r_granted;
    assign rejected    = r_rejected;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed testbench for keypad_entry_ctrl with default parameters (enter 2, timeout 8, cooldown 16).
module tb_keypad_entry_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ok;
    logic       key_clr;
    logic       access;
    logic       alarm;
    logic [1:0] count;
    logic [3:0] passin;
    logic       enter;
    logic       busy;
    logic       granted;
    logic       rejected;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

`ifdef KEYPAD_PASSIN_MASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif

    keypad_entry_ctrl #(
        .ENTER_CYCLES(2),
        .RESP_TIMEOUT(8),
        .COOLDOWN(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ok(key_ok),
        .key_clr(key_clr),
        .access(access),
        .alarm(alarm),
        .count(count),
        .passin(passin),
        .enter(enter),
        .busy(busy),
        .granted(granted),
        .rejected(rejected),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic submit;
        key_ok = 1'b1;
        tick();
        key_ok = 1'b0;
    endtask

    function automatic logic [3:0] idle_pass(input logic [3:0] d);
        return MASKED ? 4'h0 : d;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        key_valid = 1'b0; key_code = 4'h0; key_ok = 1'b0; key_clr = 1'b0;
        access = 1'b0; alarm = 1'b0; count = 2'd0;
        tick(); tick();
        tests++; if (passin !== 4'h0) begin fails++; $display("FAIL reset_passin got=%0h exp=0", passin); end
        tests++; if ({enter, busy, granted, rejected, timeout_err} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got=%05b exp=00000", {enter, busy, granted, rejected, timeout_err});
        end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_grant;
        press(4'hE);
        tests++; if (passin !== idle_pass(4'hE)) begin fails++; $display("FAIL grant_armed_passin got=%0h exp=%0h", passin, idle_pass(4'hE)); end
        submit();
        tests++; if (enter !== 1'b1) begin fails++; $display("FAIL grant_enter_c1 got=%0b exp=1", enter); end
        tests++; if (passin !== 4'hE) begin fails++; $display("FAIL grant_send_passin got=%0h exp=e", passin); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL grant_send_busy got=%0b exp=1", busy); end
        tick();
        tests++; if (enter !== 1'b1) begin fails++; $display("FAIL grant_enter_c2 got=%0b exp=1", enter); end
        tick();
        tests++; if (enter !== 1'b0) begin fails++; $display("FAIL grant_enter_c3 got=%0b exp=0", enter); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL grant_wait_busy got=%0b exp=1", busy); end
        tick();
        access = 1'b1;
        tick();
        access = 1'b0;
        tests++; if (granted !== 1'b1) begin fails++; $display("FAIL grant_granted got=%0b exp=1", granted); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL grant_idle_busy got=%0b exp=0", busy); end
        submit();
        tests++; if (enter !== 1'b0) begin fails++; $display("FAIL grant_idle_ok_ignored got=%0b exp=0", enter); end
    endtask

    task automatic test_reject;
        key_clr = 1'b1; tick(); key_clr = 1'b0;
        tests++; if (granted !== 1'b0) begin fails++; $display("FAIL reject_clr_granted got=%0b exp=0", granted); end
        press(4'hA);
        submit(); tick(); tick();
        count = 2'd1;
        tick();
        tests++; if (rejected !== 1'b1) begin fails++; $display("FAIL reject_pulse got=%0b exp=1", rejected); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reject_busy got=%0b exp=0", busy); end
        tests++; if (passin !== idle_pass(4'hA)) begin fails++; $display("FAIL reject_passin got=%0h exp=%0h", passin, idle_pass(4'hA)); end
        tests++; if (granted !== 1'b0) begin fails++; $display("FAIL reject_granted got=%0b exp=0", granted); end
        tick();
        tests++; if (rejected !== 1'b0) begin fails++; $display("FAIL reject_pulse_width got=%0b exp=0", rejected); end
        // still ARMED with digit A: retry snapshots count=1
        submit();
        tests++; if (enter !== 1'b1) begin fails++; $display("FAIL reject_retry_enter got=%0b exp=1", enter); end
        tests++; if (passin !== 4'hA) begin fails++; $display("FAIL reject_retry_passin got=%0h exp=a", passin); end
        tick(); tick(); tick();
        tests++; if (rejected !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL reject_snap_hold got=%0b%0b exp=01", rejected, busy);
        end
        count = 2'd0;
        tick();
        tests++; if (rejected !== 1'b1) begin fails++; $display("FAIL reject_second got=%0b exp=1", rejected); end
    endtask

    task automatic test_alarm;
        int n;
        press(4'h9);
        submit(); tick(); tick();
        alarm = 1'b1;
        tick();
        alarm = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 5) begin key_valid = 1'b1; key_code = 4'h3; key_ok = 1'b1; end
            else begin key_valid = 1'b0; key_ok = 1'b0; end
            tick();
        end
        key_valid = 1'b0; key_ok = 1'b0;
        tests++; if (n !== 16) begin fails++; $display("FAIL alarm_cooldown_len got=%0d exp=16", n); end
        tests++; if (passin !== 4'h0) begin fails++; $display("FAIL alarm_digit_cleared got=%0h exp=0", passin); end
        tests++; if (enter !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL alarm_idle got=%0b%0b exp=00", enter, busy); end
        submit();
        tests++; if (enter !== 1'b0) begin fails++; $display("FAIL alarm_idle_ok_ignored got=%0b exp=0", enter); end
    endtask

    task automatic test_timeout;
        press(4'h5);
        submit(); tick(); tick();
        repeat (7) tick();
        tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL timeout_early got=%0b%0b exp=01", timeout_err, busy);
        end
        tick();
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_set got=%0b exp=1", timeout_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
        tests++; if (passin !== idle_pass(4'h5)) begin fails++; $display("FAIL timeout_passin got=%0h exp=%0h", passin, idle_pass(4'h5)); end
        submit();
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_ok_clears got=%0b exp=0", timeout_err); end
        tests++; if (enter !== 1'b1) begin fails++; $display("FAIL timeout_resend got=%0b exp=1", enter); end
        tick(); tick();
        access = 1'b1; tick(); access = 1'b0;
        tests++; if (granted !== 1'b1) begin fails++; $display("FAIL timeout_grant got=%0b exp=1", granted); end
    endtask

    task automatic test_reset_mid_send;
        press(4'h7);
        submit();
        tests++; if (enter !== 1'b1) begin fails++; $display("FAIL rstsend_enter_pre got=%0b exp=1", enter); end
        #2 reset = 1'b1;
        #1;
        tests++; if (enter !== 1'b0) begin fails++; $display("FAIL rstsend_enter_async got=%0b exp=0", enter); end
        tests++; if ({busy, granted, rejected, timeout_err} !== 4'b0 || passin !== 4'h0) begin
            fails++; $display("FAIL rstsend_outputs got=%04b/%0h exp=0000/0", {busy, granted, rejected, timeout_err}, passin);
        end
        reset = 1'b0;
        tick();
        submit();
        tests++; if (enter !== 1'b0) begin fails++; $display("FAIL rstsend_abandoned got=%0b exp=0", enter); end
    endtask

    task automatic test_clr_ok;
        press(4'h6);
        tests++; if (passin !== idle_pass(4'h6)) begin fails++; $display("FAIL clr_armed_passin got=%0h exp=%0h", passin, idle_pass(4'h6)); end
        key_clr = 1'b1; key_ok = 1'b1;
        tick();
        key_clr = 1'b0; key_ok = 1'b0;
        tests++; if (enter !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL clr_wins got=%0b%0b exp=00", enter, busy); end
        tests++; if (passin !== 4'h0) begin fails++; $display("FAIL clr_passin got=%0h exp=0", passin); end
        access = 1'b1; tick(); access = 1'b0;
        tests++; if (granted !== 1'b0) begin fails++; $display("FAIL clr_access_outside_wait got=%0b exp=0", granted); end
        submit();
        tests++; if (enter !== 1'b0) begin fails++; $display("FAIL clr_idle_ok got=%0b exp=0", enter); end
    endtask

    task automatic test_back_to_back;
        press(4'h3);
        press(4'hC);
        submit();
        tests++; if (passin !== 4'hC || enter !== 1'b1) begin
            fails++; $display("FAIL b2b_overwrite got=%0h/%0b exp=c/1", passin, enter);
        end
        key_valid = 1'b1; key_code = 4'h1;
        tick();
        key_valid = 1'b0;
        tests++; if (passin !== 4'hC) begin fails++; $display("FAIL b2b_send_key_ignored got=%0h exp=c", passin); end
        tick();
        access = 1'b1; tick(); access = 1'b0;
        tests++; if (granted !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_grant got=%0b%0b exp=10", granted, busy); end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_reject();
        test_alarm();
        test_timeout();
        test_reset_mid_send();
        test_clr_ok();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameters: ENTER_CYCLES, default 2, enter pulse width in cycles (1..15); RESP_TIMEOUT, default 8, max cycles to wait for a lock response (1..255); COOLDOWN, default 16, lockout cycles after alarm (1..255).
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
REQ-005 key_code  in  4  digit pressed by the user.
REQ-006 key_ok  in  1  one-cycle submit strobe.
REQ-007 key_clr  in  1  one-cycle clear strobe.
REQ-008 access  in  1  lock grant indication.
REQ-009 alarm  in  1  lock alarm indication.
REQ-010 count  in  2  lock wrong-attempt counter.
REQ-011 passin  out  4  code presented to the lock.
REQ-012 enter  out  1  submit pulse to the lock.
REQ-013 busy  out  1  high in SEND, WAIT and COOLDOWN.
REQ-014 granted  out  1  sticky, set on access, cleared by key_clr.
REQ-015 rejected  out  1  one-cycle pulse on a failed attempt.
REQ-016 timeout_err  out  1  sticky, set on response timeout, cleared by key_clr or the next key_ok.

Function
REQ-017 States: IDLE, ARMED, SEND, WAIT, COOLDOWN; registered outputs only.
REQ-018 IDLE/ARMED: key_valid captures key_code into digit_r and enters ARMED; later key_valid overwrites digit_r.
REQ-019 ARMED + key_ok -> SEND; key_ok in IDLE is ignored.
REQ-020 On entering SEND, snapshot count into cnt_snap; enter is high for exactly ENTER_CYCLES cycles, then WAIT.
REQ-021 WAIT, priority high to low: alarm=1 -> COOLDOWN; access=1 -> set granted, go to IDLE; count != cnt_snap -> rejected pulse, go to ARMED with digit retained; RESP_TIMEOUT cycles elapsed -> set timeout_err, go to ARMED.
REQ-022 COOLDOWN lasts exactly COOLDOWN cycles, then IDLE with digit_r cleared to 0; all key inputs are ignored during COOLDOWN.
REQ-023 key_valid, key_ok and key_clr are ignored in SEND and WAIT; a new attempt is never interleaved with an outstanding one.
REQ-024 key_clr in IDLE/ARMED: digit_r=0, granted=0, timeout_err=0, go to IDLE; key_clr wins over key_valid and key_ok in the same cycle.
REQ-025 Counters saturate at their terminal values and never wrap; the timeout counter resets on every entry into WAIT.
REQ-026 access asserted outside WAIT does not set granted.

Reset
REQ-027 On reset assertion: state=IDLE; digit_r=0, cnt_snap=0; passin=0, enter=0, busy=0, granted=0, rejected=0, timeout_err=0.
REQ-028 Reset asserted mid-SEND drops enter in the same cycle (asynchronous); the attempt is abandoned.

Configuration
REQ-029 Macro KEYPAD_PASSIN_MASK_EN:
- Defined: passin = digit_r only in SEND and WAIT, else 0.
- Undefined: passin = digit_r continuously.
- All other behaviour is identical in both builds.

Verification
REQ-030 key_valid code=0xE, key_ok, then access=1 on the 2nd WAIT cycle -> enter high for 2 cycles, passin=0xE during SEND, granted=1, state IDLE.
REQ-031 code=0xA, key_ok, count changes 0->1 in WAIT -> one-cycle rejected pulse, state ARMED, digit_r=0xA, granted=0.
REQ-032 code=0x9, key_ok, alarm=1 in WAIT -> busy stays high for 16 cycles; key_valid during this window is ignored; then IDLE with digit_r=0.
REQ-033 code=0x5, key_ok, no response -> timeout_err=1 after 8 WAIT cycles, state ARMED; the next key_ok clears timeout_err.
REQ-034 reset pulsed while enter=1 -> enter=0 immediately; all outputs at reset values.
REQ-035 key_clr and key_ok in the same cycle in ARMED -> IDLE with no enter pulse; check passin=0 in IDLE with KEYPAD_PASSIN_MASK_EN defined, and passin=digit_r with it undefined.
